// File: rtl/fetch_stage.sv
// Purpose : instruction-fetch stage; owns the PC, addresses imem, fills the IF/ID register.
// Latency : 1 cycle from the edge that samples pc_f to instr_d/pc_d/valid_d.
// Backpressure: stall_f holds the PC, stall_d holds IF/ID, flush_d inserts a bubble.
//
// Ports:
//   clk, rst            pipeline clock; synchronous active-low reset
//   stall_f, stall_d    fetch / decode stalls from the hazard unit
//   flush_d             replace IF/ID with a NOP bubble (wins over stall_d)
//   pc_src_e,
//   pc_target_e         taken branch/jump redirect from execute (wins over stall_f)
//   instr_f             combinational imem read data for pc_f
//   pc_f                current fetch PC (imem address)
//   instr_d, pc_d,
//   pc_plus4_d, valid_d IF/ID pipeline register
//   fetch_count         saturating count of valid captures into IF/ID
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             pc_src_e,
  input  logic [31:0]      pc_target_e,
  input  logic [31:0]      instr_f,
  output logic [31:0]      pc_f,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc_plus4_d,
  output logic             valid_d,
  output logic [CNT_W-1:0] fetch_count
);

  logic [31:0]      pc_f_q,       pc_f_d;
  logic [31:0]      instr_d_q,    instr_d_d;
  logic [31:0]      pc_d_q,       pc_d_d;
  logic [31:0]      pc_plus4_d_q, pc_plus4_d_d;
  logic             valid_d_q,    valid_d_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             capture;

  // Next PC: redirect beats stall; target is forced word-aligned.
  always_comb begin
    pc_f_d = pc_f_q + 32'd4;
    if (pc_src_e) begin
      pc_f_d = {pc_target_e[31:2], 2'b00};
    end else if (stall_f) begin
      pc_f_d = pc_f_q;
    end
  end

  // IF/ID register: flush beats stall; capture only on the plain path.
  always_comb begin
    instr_d_d    = instr_d_q;
    pc_d_d       = pc_d_q;
    pc_plus4_d_d = pc_plus4_d_q;
    valid_d_d    = valid_d_q;
    capture      = 1'b0;
    if (flush_d) begin
      instr_d_d    = NOP_INSTR;
      pc_d_d       = 32'd0;
      pc_plus4_d_d = 32'd0;
      valid_d_d    = 1'b0;
    end else if (!stall_d) begin
      instr_d_d    = instr_f;
      pc_d_d       = pc_f_q;
      pc_plus4_d_d = pc_f_q + 32'd4;
      valid_d_d    = 1'b1;
      capture      = 1'b1;
    end
  end

  // Counter saturates at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (capture && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset overrides everything, so the zero word imem returns during reset is never captured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_f_q       <= RESET_PC;
      instr_d_q    <= NOP_INSTR;
      pc_d_q       <= 32'd0;
      pc_plus4_d_q <= 32'd0;
      valid_d_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      pc_f_q       <= pc_f_d;
      instr_d_q    <= instr_d_d;
      pc_d_q       <= pc_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pc_f        = pc_f_q;
  assign instr_d     = instr_d_q;
  assign pc_d        = pc_d_q;
  assign pc_plus4_d  = pc_plus4_d_q;
  assign valid_d     = valid_d_q;
  assign fetch_count = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the RISC pipeline. Owns the program counter, drives the instruction-memory address, and registers the returned word into the IF/ID pipeline register together with its PC, PC+4 and a valid bit. Sits directly upstream of the instruction memory (which it addresses) and of the decode stage (which it feeds). Honours stall, flush and branch/jump redirect controls from the hazard unit and execute stage.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000013, instruction word inserted into IF/ID on reset or flush (addi x0,x0,0).
CNT_W, 16, width of the retired-fetch counter.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
stall_f  in  1  hold PC (fetch stall).
stall_d  in  1  hold IF/ID register (decode stall).
flush_d  in  1  replace IF/ID contents with a bubble.
pc_src_e  in  1  redirect request from execute (taken branch/jump).
pc_target_e  in  32  redirect target address.
instr_f  in  32  instruction word from instruction memory (combinational read of pc_f).
pc_f  out  32  current fetch PC; drives instruction-memory address bits [31:0]; the upper address bits are tied to 0 at top level.
instr_d  out  32  registered instruction to decode.
pc_d  out  32  PC of instr_d.
pc_plus4_d  out  32  pc_d + 4.
valid_d  out  1  instr_d is a real fetched instruction (0 = bubble).
fetch_count  out  CNT_W  number of valid instructions delivered to decode.

Behaviour:
- Reset (rst==0 at posedge): pc_f<=RESET_PC; instr_d<=NOP_INSTR; pc_d<=0; pc_plus4_d<=0; valid_d<=0; fetch_count<=0. Reset overrides every other input. The memory returns 0 while rst is low; that word must never be captured.
- Next-PC priority, highest first:
  1. pc_src_e=1: pc_f<={pc_target_e[31:2],2'b00}. Redirect wins over stall_f. Low two bits are always forced to 0.
  2. stall_f=1: pc_f holds.
  3. Otherwise: pc_f<=pc_f+4, modulo 2^32. 32'hFFFFFFFC wraps to 0.
- IF/ID priority, highest first:
  1. flush_d=1: instr_d<=NOP_INSTR; valid_d<=0; pc_d and pc_plus4_d<=0. Flush wins over stall_d.
  2. stall_d=1: all IF/ID outputs hold.
  3. Otherwise: instr_d<=instr_f; pc_d<=pc_f; pc_plus4_d<=pc_f+4; valid_d<=1.
- Latency: the word at address pc_f appears on instr_d one clock after the edge that samples it. The first valid_d=1 occurs on the first rising edge after rst goes high, and carries pc_d=RESET_PC.
- Redirect without flush_d: the wrong-path word already in fetch is still captured. Squashing it is the hazard unit's job, which asserts flush_d in the same cycle as pc_src_e.
- stall_f=1 with stall_d=0 and no flush: the same PC is captured again. This is legal; the hazard unit never issues that combination.
- fetch_count: increments by 1 on each edge that takes the "otherwise" IF/ID branch (valid capture). It saturates at 2^CNT_W-1 and does not wrap. It holds on stall or flush.
- No combinational path from any input to pc_f. The instr_f-to-IF/ID path is the only combinational dependency on memory.

Test Plan:
- Reset then free-run, with memory word0=32'h00100093 and word1=32'h00200113: at edge 1 after release, pc_d=0, instr_d=32'h00100093, valid_d=1. At edge 2, pc_d=4, pc_plus4_d=8, instr_d=32'h00200113, fetch_count=2.
- stall_f=1 and stall_d=1 for 3 cycles at pc_f=8: pc_f stays 8, IF/ID outputs and fetch_count frozen. On release, the next capture has pc_d=8.
- pc_src_e=1, pc_target_e=32'h00000013, flush_d=1 in the same cycle: next edge pc_f=32'h00000010, instr_d=32'h00000013, valid_d=0. The following edge captures pc_d=16.
- Redirect, flush_d and stall_f all asserted together: redirect and flush take effect (pc_f=target, valid_d=0), showing that stall is overridden.
- rst driven low mid-run at pc_f=32'h24 with stall_d=1: next edge pc_f=0, valid_d=0, instr_d=32'h00000013, fetch_count=0.
- Force pc_f=32'hFFFFFFFC via redirect, then run 1 cycle: pc_f=0. With CNT_W=2, 5 valid captures leave fetch_count=3 (saturated).
